// File: rtl/sdram_cpu_port.sv
// CPU byte-strobe to SDRAM toggle req/ack bridge with read capture and ordering.
// Define SDRAM_CPU_PORT_WBUF_EN to build in the posted-write FIFO.
module sdram_cpu_port #(
    parameter int WBUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_cpu_cs,
    input  logic        i_cpu_we,
    input  logic [23:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_din,
    output logic [7:0]  o_cpu_dout,
    output logic        o_cpu_rdy,
    output logic        o_cpu_busy,
    output logic        o_sd_req,
    input  logic        i_sd_ack,
    output logic        o_sd_we,
    output logic [22:0] o_sd_a,
    output logic [1:0]  o_sd_ds,
    output logic [15:0] o_sd_d,
    input  logic [7:0]  i_sd_q
);

    localparam int PW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE_RD, S_ISSUE_WR, S_DRAIN, S_WAIT
    } state_t;

    state_t        r_state, w_next;
    logic          r_req, r_inflight, r_we, r_rdy;
    logic [22:0]   r_a;
    logic [1:0]    r_ds;
    logic [15:0]   r_d;
    logic [7:0]    r_dout, r_cd;
    logic [23:0]   r_ca;

    logic          w_pend, w_can_issue, w_done, w_strobe, w_busy;
    logic          w_empty, w_full, w_pop;
    logic [PW:0]   w_cnt;
    logic [31:0]   w_head;
    logic          w_issue, w_iwe;
    logic [23:0]   w_iaddr;
    logic [7:0]    w_idin;

    assign w_pend      = r_req != i_sd_ack;
    assign w_can_issue = !r_inflight && !w_pend;
    assign w_done      = r_inflight && !w_pend;
    assign w_empty     = w_cnt == '0;
    assign w_full      = w_cnt == (PW+1)'(WBUF_DEPTH);
    assign w_pop       = w_done && r_we && !w_empty;
    assign w_strobe    = i_cpu_cs && !w_busy;

`ifdef SDRAM_CPU_PORT_WBUF_EN
    logic [31:0] r_mem [WBUF_DEPTH];
    logic [PW-1:0] r_wp, r_rp;
    logic [PW:0]   r_cnt;
    logic          w_push;

    assign w_push = w_strobe && i_cpu_we;
    assign w_busy = (r_state != S_IDLE) || w_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            if (w_push && !w_pop)
                r_cnt <= r_cnt + 1'b1;
            else if (w_pop && !w_push)
                r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= {i_cpu_addr, i_cpu_din};
    end

    assign w_cnt  = r_cnt;
    assign w_head = r_mem[r_rp];
`else
    assign w_busy = (r_state != S_IDLE) || w_full || w_pend;
    assign w_cnt  = '0;
    assign w_head = '0;
`endif

    always_comb begin
        w_next  = r_state;
        w_issue = 1'b0;
        w_iwe   = 1'b0;
        w_iaddr = r_ca;
        w_idin  = r_cd;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty && w_can_issue) begin
                    w_issue = 1'b1;
                    w_iwe   = 1'b1;
                    w_iaddr = w_head[31:8];
                    w_idin  = w_head[7:0];
                end
                if (w_strobe && !i_cpu_we)
                    w_next = w_empty ? S_ISSUE_RD : S_DRAIN;
`ifndef SDRAM_CPU_PORT_WBUF_EN
                if (w_strobe && i_cpu_we)
                    w_next = S_ISSUE_WR;
`endif
            end
            S_DRAIN: begin
                if (!w_empty && w_can_issue) begin
                    w_issue = 1'b1;
                    w_iwe   = 1'b1;
                    w_iaddr = w_head[31:8];
                    w_idin  = w_head[7:0];
                end
                if ((w_empty && !r_inflight) ||
                    (w_pop && w_cnt == (PW+1)'(1)))
                    w_next = S_ISSUE_RD;
            end
            S_ISSUE_RD: begin
                if (w_can_issue) begin
                    w_issue = 1'b1;
                    w_next  = S_WAIT;
                end
            end
            S_ISSUE_WR: begin
                if (w_can_issue) begin
                    w_issue = 1'b1;
                    w_iwe   = 1'b1;
                    w_next  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_done) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_req      <= i_sd_ack;
            r_inflight <= 1'b0;
            r_we       <= 1'b0;
            r_a        <= '0;
            r_ds       <= 2'b00;
            r_d        <= '0;
            r_dout     <= '0;
            r_rdy      <= 1'b0;
            r_ca       <= '0;
            r_cd       <= '0;
        end else begin
            r_state <= w_next;
            r_rdy   <= (r_state == S_WAIT) && w_done && !r_we;
            if ((r_state == S_WAIT) && w_done && !r_we)
                r_dout <= i_sd_q;
            if (w_strobe) begin
                r_ca <= i_cpu_addr;
                r_cd <= i_cpu_din;
            end
            if (w_issue) begin
                r_req      <= ~r_req;
                r_inflight <= 1'b1;
                r_we       <= w_iwe;
                r_a        <= w_iaddr[23:1];
                r_ds       <= w_iaddr[0] ? 2'b01 : 2'b10;
                r_d        <= {w_idin, w_idin};
            end else if (w_done) begin
                r_inflight <= 1'b0;
            end else if (!r_inflight && w_pend) begin
                // ack of a request abandoned by reset: follow it silently
                r_req <= i_sd_ack;
            end
        end
    end

    assign o_cpu_dout = r_dout;
    assign o_cpu_rdy  = r_rdy;
    assign o_cpu_busy = w_busy;
    assign o_sd_req   = r_req;
    assign o_sd_we    = r_we;
    assign o_sd_a     = r_a;
    assign o_sd_ds    = r_ds;
    assign o_sd_d     = r_d;

endmodule

// File: tb/tb_sdram_cpu_port.sv
// Bench for sdram_cpu_port: SDRAM client model plus request/read scoreboards.
// Covers the default build and, when SDRAM_CPU_PORT_WBUF_EN is set, the FIFO build.
module tb_sdram_cpu_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs, we;
    logic [23:0] addr;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        rdy, busy;
    logic        sd_req;
    logic        sd_ack = 1'b0;
    logic        sd_we;
    logic [22:0] sd_a;
    logic [1:0]  sd_ds;
    logic [15:0] sd_d;
    logic [7:0]  sd_q = 8'h00;

    typedef struct packed {
        logic        we;
        logic [22:0] a;
        logic [1:0]  ds;
        logic [15:0] d;
    } req_t;

    req_t       exp_req[$];
    logic [7:0] exp_rd[$];
    logic [7:0] mem     [0:511];
    logic [7:0] ref_mem [0:511];

    int total = 0;
    int passed = 0;
    bit hold = 1'b0;
    int dly = 5;
    int force_req = 0;
    int force_done = 0;

    sdram_cpu_port #(.WBUF_DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .i_cpu_cs(cs), .i_cpu_we(we),
        .i_cpu_addr(addr), .i_cpu_din(din),
        .o_cpu_dout(dout), .o_cpu_rdy(rdy),
        .o_cpu_busy(busy), .o_sd_req(sd_req),
        .i_sd_ack(sd_ack), .o_sd_we(sd_we),
        .o_sd_a(sd_a), .o_sd_ds(sd_ds),
        .o_sd_d(sd_d), .i_sd_q(sd_q)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] bidx(input logic [22:0] a,
                                        input logic [1:0] ds);
        return {a[7:0], ds == 2'b01};
    endfunction

    // SDRAM client model and read-data scoreboard, sampled 1 after posedge
    bit   seen = 1'b0;
    bit   tog_prev = 1'b0;
    int   cnt = 0;
    req_t cap, er;
    logic [7:0] erd;
    always begin
        @(posedge clk);
        #1;
        if (rdy === 1'b1) begin
            total++;
            if (exp_rd.size() == 0) begin
                $display("FAIL spurious_rdy dout=%h", dout);
            end else begin
                erd = exp_rd.pop_front();
                if (dout !== erd || !tog_prev)
                    $display("FAIL rd_data got=%h exp=%h ack_prev=%0d",
                             dout, erd, tog_prev);
                else
                    passed++;
            end
        end
        tog_prev = 1'b0;
        if (reset === 1'b1) begin
            seen = 1'b0;
        end else if (force_req != force_done) begin
            force_done = force_req;
            sd_ack = ~sd_ack;
            seen = 1'b0;
        end else if (!hold && sd_req !== sd_ack) begin
            if (!seen) begin
                seen = 1'b1;
                cnt = 0;
                cap = {sd_we, sd_a, sd_ds, sd_d};
                total++;
                if (exp_req.size() == 0) begin
                    $display("FAIL unexpected_req got=%h", cap);
                end else begin
                    er = exp_req.pop_front();
                    if (cap !== er)
                        $display("FAIL req_fields got=%h exp=%h", cap, er);
                    else
                        passed++;
                end
            end
            cnt++;
            if (cnt >= dly) begin
                total++;
                if ({sd_we, sd_a, sd_ds, sd_d} !== cap)
                    $display("FAIL req_hold got=%h exp=%h",
                             {sd_we, sd_a, sd_ds, sd_d}, cap);
                else
                    passed++;
                if (sd_we)
                    mem[bidx(sd_a, sd_ds)] =
                        (sd_ds == 2'b01) ? sd_d[7:0] : sd_d[15:8];
                else
                    sd_q = mem[bidx(sd_a, sd_ds)];
                sd_ack = ~sd_ack;
                seen = 1'b0;
                tog_prev = 1'b1;
            end
        end
    end

    task automatic do_cpu(input bit w, input logic [23:0] a,
                          input logic [7:0] d, output bit acc);
        @(negedge clk);
        cs = 1'b1; we = w; addr = a; din = d;
        acc = !busy;
        if (acc) begin
            exp_req.push_back({w, a[23:1], a[0] ? 2'b01 : 2'b10, {d, d}});
            if (w) ref_mem[a[8:0]] = d;
            else   exp_rd.push_back(ref_mem[a[8:0]]);
        end
        @(negedge clk);
        cs = 1'b0;
    endtask

    task automatic wait_free();
        int n = 0;
        while (busy !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            total++;
            $display("FAIL busy_timeout busy=%b", busy);
        end
    endtask

    task automatic cpu(input bit w, input logic [23:0] a,
                       input logic [7:0] d);
        bit acc;
        wait_free();
        do_cpu(w, a, d, acc);
        total++;
        if (acc !== 1'b1) $display("FAIL accept got=%b exp=1", acc);
        else passed++;
    endtask

    task automatic settle(input string nm);
        int n = 0;
        while ((busy !== 1'b0 || sd_req !== sd_ack ||
                exp_req.size() != 0 || exp_rd.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 400)
            $display("FAIL settle_%s busy=%b reqs=%0d rds=%0d exp=drained",
                     nm, busy, exp_req.size(), exp_rd.size());
        else
            passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cs = 1'b0; we = 1'b0; addr = '0; din = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        total++;
        if ({dout, rdy, busy} !== 10'h0)
            $display("FAIL rst_cpu got=%h exp=0", {dout, rdy, busy});
        else passed++;
        total++;
        if (sd_req !== 1'b0)
            $display("FAIL rst_req got=%b exp=0", sd_req);
        else passed++;
        total++;
        if ({sd_we, sd_a, sd_ds, sd_d} !== 42'h0)
            $display("FAIL rst_sd got=%h exp=0", {sd_we, sd_a, sd_ds, sd_d});
        else passed++;
    endtask

    task automatic test_read();
        dly = 5;
        cpu(1'b0, 24'h000101, 8'h00);
        total++;
        if (busy !== 1'b1) $display("FAIL rd_busy got=%b exp=1", busy);
        else passed++;
        settle("read");
        repeat (3) @(negedge clk);
        total++;
        if (dout !== 8'hA5) $display("FAIL rd_hold got=%h exp=a5", dout);
        else passed++;
    endtask

    task automatic test_write_read();
        cpu(1'b1, 24'h000010, 8'h55);
        cpu(1'b0, 24'h000010, 8'h00);
        settle("wr_rd");
        total++;
        if (mem[9'h010] !== 8'h55)
            $display("FAIL wr_mem got=%h exp=55", mem[9'h010]);
        else passed++;
    endtask

`ifdef SDRAM_CPU_PORT_WBUF_EN
    task automatic test_buffered();
        bit acc;
        hold = 1'b1;
        do_cpu(1'b1, 24'h000020, 8'h3C, acc);
        total++;
        if (acc !== 1'b1 || busy !== 1'b0)
            $display("FAIL buf_first acc=%b busy=%b exp=1,0", acc, busy);
        else passed++;
        do_cpu(1'b1, 24'h000021, 8'h7E, acc);
        total++;
        if (acc !== 1'b1 || busy !== 1'b1)
            $display("FAIL buf_full acc=%b busy=%b exp=1,1", acc, busy);
        else passed++;
        do_cpu(1'b1, 24'h000022, 8'h99, acc);
        total++;
        if (acc !== 1'b0) $display("FAIL buf_drop acc=%b exp=0", acc);
        else passed++;
        hold = 1'b0;
        settle("buf");
        total++;
        if ({mem[9'h020], mem[9'h021], mem[9'h022]} !== 24'h3C7E00)
            $display("FAIL buf_mem got=%h exp=3c7e00",
                     {mem[9'h020], mem[9'h021], mem[9'h022]});
        else passed++;
    endtask
`else
    task automatic test_unbuf_write();
        int  n = 0;
        bit  bad = 1'b0;
        cpu(1'b1, 24'h000003, 8'h12);
        while (busy === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
            if (sd_req !== sd_ack && busy !== 1'b1) bad = 1'b1;
        end
        total++;
        if (bad || n < 6 || n >= 100)
            $display("FAIL unbuf_busy cycles=%0d bad=%b exp=busy_until_ack",
                     n, bad);
        else passed++;
        total++;
        if (mem[9'h003] !== 8'h12 || dout !== 8'h55)
            $display("FAIL unbuf_wr mem=%h dout=%h exp=12,55",
                     mem[9'h003], dout);
        else passed++;
        settle("unbuf");
    endtask
`endif

    task automatic test_drop();
        bit   acc;
        logic r;
        hold = 1'b1;
        cpu(1'b1, 24'h000030, 8'h11);
`ifdef SDRAM_CPU_PORT_WBUF_EN
        cpu(1'b1, 24'h000031, 8'h22);
`endif
        repeat (2) @(negedge clk);
        r = sd_req;
        do_cpu(1'b0, 24'h000031, 8'h00, acc);
        total++;
        if (acc !== 1'b0) $display("FAIL drop_acc got=%b exp=0", acc);
        else passed++;
        repeat (3) @(negedge clk);
        total++;
        if (sd_req !== r) $display("FAIL drop_req got=%b exp=%b", sd_req, r);
        else passed++;
        hold = 1'b0;
        settle("drop");
    endtask

    task automatic test_reset_mid();
        int n = 0;
        if (sd_ack !== 1'b1) begin
            cpu(1'b0, 24'h000101, 8'h00);
            settle("parity");
        end
        hold = 1'b1;
        cpu(1'b0, 24'h000040, 8'h00);
        while (sd_req === sd_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (sd_req !== 1'b0 || sd_ack !== 1'b1)
            $display("FAIL mid_issue req=%b ack=%b exp=0,1", sd_req, sd_ack);
        else passed++;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_req.delete();
        exp_rd.delete();
        total++;
        if ({sd_req, busy, rdy, dout} !== 11'h400)
            $display("FAIL mid_rst req=%b busy=%b rdy=%b dout=%h exp=1,0,0,0",
                     sd_req, busy, rdy, dout);
        else passed++;
        repeat (3) @(negedge clk);
        total++;
        if (sd_req !== 1'b1) $display("FAIL mid_notog got=%b exp=1", sd_req);
        else passed++;
        force_req++;
        repeat (4) @(negedge clk);
        total++;
        if (sd_req !== sd_ack || sd_ack !== 1'b0 || rdy !== 1'b0)
            $display("FAIL mid_absorb req=%b ack=%b rdy=%b exp=0,0,0",
                     sd_req, sd_ack, rdy);
        else passed++;
        hold = 1'b0;
        cpu(1'b0, 24'h000101, 8'h00);
        settle("recover");
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        mem[9'h101] = 8'hA5;
        ref_mem[9'h101] = 8'hA5;
        test_reset();
        test_read();
        test_write_read();
`ifdef SDRAM_CPU_PORT_WBUF_EN
        test_buffered();
`else
        test_unbuf_write();
`endif
        test_drop();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
